// File: rtl/norm_pipe.sv
`timescale 1ns/1ps
// norm_pipe: two-stage post-add normaliser with valid/ready flow control,
// sticky-preserving right shift, denormal clamping and overflow/zero flags.
module norm_pipe #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero_out,
  output logic              denorm_out,
  output logic              ovf_out
);
  localparam int LZW = $clog2(MANT_W);
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  logic              s1_v_q, s1_carry_q;
  logic [MANT_W-1:0] s1_mant_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [LZW-1:0]    s1_lzc_q, lzc_d;
  logic              out_valid_q, zero_q, denorm_q, ovf_q;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d, dsh;
  logic              zero_d, denorm_d, ovf_d, s2_load;
  logic [EXP_W:0]    e_x, lz_x, ep1;
  // lzc over the hidden bit and below; all-zero yields MANT_W-1
  always_comb begin
    lzc_d = LZW'(MANT_W-1);
    for (int i = 0; i < MANT_W-1; i++)
      if (mant_in[i]) lzc_d = LZW'(MANT_W-2-i);
  end
  assign s2_load = !out_valid_q || out_ready;
  assign in_ready = !s1_v_q || s2_load;
  assign e_x  = {1'b0, s1_exp_q};
  assign lz_x = (EXP_W+1)'(s1_lzc_q);
  assign ep1  = e_x + (EXP_W+1)'(1);
  assign dsh  = (s1_exp_q != '0) ? s1_exp_q - EXP_W'(1) : '0;
  always_comb begin
    mant_d   = '0;
    exp_d    = '0;
    zero_d   = 1'b0;
    denorm_d = 1'b0;
    ovf_d    = 1'b0;
    if (s1_mant_q == '0) begin
      zero_d = 1'b1;
    end else if (s1_carry_q) begin
      if (ep1 >= EMAX) begin
        ovf_d = 1'b1;
        exp_d = {EXP_W{1'b1}};
      end else begin
        mant_d = {1'b0, s1_mant_q[MANT_W-1:2], s1_mant_q[1] | s1_mant_q[0]};
        exp_d  = ep1[EXP_W-1:0];
      end
    end else if (s1_mant_q[MANT_W-2]) begin
      mant_d = s1_mant_q;
      exp_d  = s1_exp_q;
    end else if (lz_x < e_x) begin
      mant_d = s1_mant_q << s1_lzc_q;
      exp_d  = EXP_W'(e_x - lz_x);
    end else begin
      mant_d   = s1_mant_q << dsh;
      denorm_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_carry_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      s1_lzc_q    <= '0;
      out_valid_q <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      zero_q      <= 1'b0;
      denorm_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_mant_q  <= mant_in;
          s1_exp_q   <= exp_in;
          s1_carry_q <= mant_in[MANT_W-1];
          s1_lzc_q   <= lzc_d;
        end
      end
      if (s2_load) begin
        out_valid_q <= s1_v_q;
        if (s1_v_q) begin
          mant_q   <= mant_d;
          exp_q    <= exp_d;
          zero_q   <= zero_d;
          denorm_q <= denorm_d;
          ovf_q    <= ovf_d;
        end
      end
    end
  end
  assign out_valid  = out_valid_q;
  assign mant_out   = mant_q;
  assign exp_out    = exp_q;
  assign zero_out   = zero_q;
  assign denorm_out = denorm_q;
  assign ovf_out    = ovf_q;
endmodule

// File: tb/tb_norm_pipe.sv
`timescale 1ns/1ps
// tb_norm_pipe: directed and random stimulus for norm_pipe, checked against
// an iterative normalisation model through an in-order scoreboard.
module tb_norm_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, zero_out, denorm_out, ovf_out;
  logic [27:0] mant_in = '0, mant_out;
  logic [7:0]  exp_in = '0, exp_out;
  typedef struct packed {
    logic [27:0] m;
    logic [7:0]  e;
    logic        z, d, o;
  } res_t;
  res_t q[$];
  int   checks = 0, passed = 0;
  res_t got, saved, cur;
  norm_pipe #(.MANT_W(28), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .exp_out(exp_out), .zero_out(zero_out),
    .denorm_out(denorm_out), .ovf_out(ovf_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  // shift one place at a time until the hidden bit appears or exponent reaches 1
  function automatic res_t model(input logic [27:0] m, input logic [7:0] e);
    res_t r = '0;
    logic [27:0] mm = m;
    int ee = e;
    if (m == 0) r.z = 1'b1;
    else if (m[27]) begin
      if (ee + 1 >= 255) begin
        r.o = 1'b1;
        r.e = 8'hFF;
      end else begin
        r.m = {1'b0, m[27:2], m[1] | m[0]};
        r.e = 8'(ee + 1);
      end
    end else begin
      while (!mm[26] && ee > 1) begin
        mm = mm << 1;
        ee--;
      end
      r.m = mm;
      if (mm[26]) r.e = 8'(ee);
      else r.d = 1'b1;
    end
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got = {mant_out, exp_out, zero_out, denorm_out, ovf_out};
      chk("scoreboard_has_entry", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("word", 64'(got), 64'(q.pop_front()));
    end
  end
  task automatic send(input logic [27:0] m, input logic [7:0] e);
    int n = 0;
    in_valid = 1'b1;
    mant_in  = m;
    exp_in   = e;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    else q.push_back(model(m, e));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic send_rand(input int cnt);
    logic [31:0] rv;
    logic [7:0]  e;
    int k;
    for (int i = 0; i < cnt; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      k  = $urandom_range(0, 6);
      e  = k == 0 ? 8'h00 : k == 1 ? 8'h01 : k == 2 ? 8'h02 : k == 3 ? 8'hFE :
           k == 4 ? 8'hFF : 8'($urandom);
      send(($urandom_range(0, 9) == 0) ? 28'h0 : rv[27:0], e);
    end
  endtask
  initial begin
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({mant_out, exp_out, zero_out, denorm_out, ovf_out}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    send(28'h8000001, 8'h80);
    @(negedge clk);
    chk("latency_1_valid_low", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_2_valid", 64'(out_valid), 64'd1);
    chk("carry_mant", 64'(mant_out), 64'h4000001);
    chk("carry_exp", 64'(exp_out), 64'h81);
    @(posedge clk);
    #1;
    send(28'h0000400, 8'h80);
    send(28'h0000001, 8'h05);
    send(28'h0000000, 8'h55);
    send(28'h8000000, 8'hFE);
    send(28'h4000000, 8'h00);
    send(28'h0000003, 8'h01);
    send(28'h8000000, 8'hFF);
    drain();
    out_ready = 1'b0;
    fork
      begin
        send(28'h0000400, 8'h80);
        send(28'h0000001, 8'h05);
        send(28'h8000001, 8'h80);
        send(28'h0000000, 8'h55);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        saved = {mant_out, exp_out, zero_out, denorm_out, ovf_out};
        repeat (2) begin
          @(negedge clk);
          cur = {mant_out, exp_out, zero_out, denorm_out, ovf_out};
          chk("bp_stable", 64'(cur), 64'(saved));
          chk("bp_still_blocked", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    fork
      send_rand(40);
      begin
        repeat (80) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    out_ready = 1'b0;
    send(28'h0000400, 8'h80);
    send(28'h0000001, 8'h05);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outputs", 64'({mant_out, exp_out, zero_out, denorm_out, ovf_out}), 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_word", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(28'h0123456, 8'h40);
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
